twofour_counter: RTL and testbench
==================================

// Module: twofour_counter
// PURPOSE
//   24-bit free-running up-counter with a programmable terminal value.
//   Counts 0,1,...,given_value, then wraps to 0 (modulo given_value+1).
//   Peripheral timebase and tick source for the 24-bit RISC-V SoC
//   (timers, baud/refresh dividers).
// PARAMETERS
//   WIDTH  24  counter and terminal-value width in bits
// PORTS
//   clk          in   1      single clock; all state changes on rising edge
//   rst          in   1      asynchronous, active-high reset
//   given_value  in   WIDTH  terminal count; highest value count reaches
//   count        out  WIDTH  current counter value (registered)
// BEHAVIOUR
//   - One clock domain (clk). rst is asynchronous and active-high.
//   - Reset:
//     - rst=1 forces count=0 immediately, independent of clk.
//     - count holds 0 while rst stays high.
//     - Deassertion takes effect at the first rising clk edge after rst falls.
//     - A reset pulse shorter than one clock period must still clear count.
//   - Each rising clk edge with rst=0:
//     - if count == given_value: count <= 0.
//     - else: count <= count + 1 (WIDTH-bit unsigned, modulo 2^WIDTH).
//   - count is a pure register output: no combinational path from given_value.
//   - given_value is sampled every cycle (no latching) and may change at any
//     time. A new value takes effect on the next edge's comparison.
//   - Boundary cases:
//     - given_value == 0: count stays at 0.
//     - given_value == 24'hFFFFFF: full-range counter; 24'hFFFFFF -> 0.
//     - given_value lowered below the current count: no equality match, so
//       count keeps incrementing to 24'hFFFFFF, wraps to 0, then obeys the
//       new terminal value. No early clear.
//     - rst asserted mid-count: count goes to 0 at once; counting restarts
//       from 0 after release.
//   - Latency: count reflects an edge's update immediately after that edge.
//   - No X propagation: count is never X after the first rst assertion.
// STRUCTURE
//   - Shared package: localparam CNT_WIDTH = 24 (the CPU data width), used as
//     the default for WIDTH.
//   - Single flat module: one always block with asynchronous reset, plus an
//     equality compare for the wrap.
//   - No sub-module.
// TESTING
//   Setup: clk period 10 ns, first rising edge at 5 ns.
//   1. given_value=10, rst pulsed 1 ns at t=0, run to 105 ns:
//      - count=0 after reset.
//      - count=1..10 on the edges at 5..95 ns.
//      - count=0 on the edge at 105 ns.
//   2. given_value=0, 5 edges -> count stays 0 on every edge.
//   3. given_value=3, assert rst between edges while count=2 -> count=0
//      before the next edge; after release count=1,2,3,0,1.
//   4. given_value=24'hFFFFFF, force-start near the top via reset plus a
//      long run (or a shortened-WIDTH build) -> 24'hFFFFFE, 24'hFFFFFF, 0.
//   5. given_value=20, count reaches 15, then change given_value to 5 ->
//      count continues 16,17,... up to 24'hFFFFFF, wraps to 0, then cycles
//      0..5 (verify with a WIDTH=8 instance: 255 -> 0).
//   6. Change given_value from 5 to 8 while count=3 -> 4,5,6,7,8,0.

Source files
------------

// File: rtl/twofour_counter_pkg.sv
// Shared definitions for the twofour_counter timebase.
// CNT_WIDTH matches the 24-bit CPU data width of the SoC and is the
// default counter width.
package twofour_counter_pkg;

  localparam int CNT_WIDTH = 24;

endpackage : twofour_counter_pkg

// File: rtl/twofour_counter.sv
// twofour_counter: free-running up-counter with a programmable terminal value.
// Counts 0,1,...,given_value and then wraps to 0. The terminal value is
// compared for equality only, so lowering it below the current count lets
// the counter run on to all-ones and wrap naturally (no early clear).
// count is driven straight from a register; given_value only feeds the
// next-state logic.
module twofour_counter
  import twofour_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] given_value,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             at_terminal_s;

  // Next-count logic: clear on an exact terminal match, otherwise increment
  // with natural modulo-2^WIDTH wrap.
  always_comb begin
    at_terminal_s = 1'b0;
    count_next_s  = CNT_ZERO;
    if (count_r == given_value) begin
      at_terminal_s = 1'b1;
      count_next_s  = CNT_ZERO;
    end else begin
      at_terminal_s = 1'b0;
      count_next_s  = count_r + CNT_ONE;
    end
  end

  // Count register: asynchronous clear, so even a sub-cycle rst pulse zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;

endmodule : twofour_counter

// File: tb/tb_twofour_counter.sv
// Self-checking bench for twofour_counter.
// Two instances: the full 24-bit build, and an 8-bit build used to reach
// the all-ones wrap in a short run. A behavioural model (plain integer
// arithmetic) predicts both counts and is compared on every falling edge;
// directed scenarios add literal expectations that pin the model itself.
module tb_twofour_counter;
  import twofour_counter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CNT_WIDTH-1:0] gv;
  logic [CNT_WIDTH-1:0] count;
  logic [7:0]           gv8;
  logic [7:0]           count8;

  int          checks   = 0;
  int          failures = 0;
  bit          model_valid = 1'b0;
  int unsigned m24 = 0;
  int unsigned m8  = 0;

  twofour_counter #(.WIDTH(CNT_WIDTH)) dut24 (
    .clk(clk), .rst(rst), .given_value(gv), .count(count)
  );

  twofour_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .given_value(gv8), .count(count8)
  );

  // 10 ns clock, first rising edge at 5 ns.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: wrap to 0 when equal to the terminal value, else +1 mod 2^W.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m24 <= 0;
      m8  <= 0;
    end else begin
      m24 <= (m24 == gv)  ? 0 : ((m24 + 1) % 32'd16777216);
      m8  <= (m8  == gv8) ? 0 : ((m8  + 1) % 32'd256);
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model24", count, m24[23:0]);
      check("model8", {16'h0000, count8}, m8[23:0]);
    end
  end

  initial begin
    int k;
    int unsigned exp;
    bit found;

    // 1. terminal 10, 1 ns reset pulse at t=0
    rst = 1'b1;
    gv  = 24'd10;
    gv8 = 8'd0;
    #1;
    check("reset24", count, 24'd0);
    check("reset8", {16'h0000, count8}, 24'd0);
    rst = 1'b0;
    model_valid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      exp = (i <= 10) ? i : 0;
      check("t1_seq", count, exp[23:0]);
    end

    // 2. terminal 0: count holds at 0
    gv = 24'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t2_zero", count, 24'd0);
    end

    // 3. terminal 3, reset asserted between edges while count=2
    gv = 24'd3;
    @(posedge clk); #1;
    check("t3_pre1", count, 24'd1);
    @(posedge clk); #1;
    check("t3_pre2", count, 24'd2);
    #1 rst = 1'b1;
    #1 check("t3_async_clr", count, 24'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp = (i + 1) % 4;
      check("t3_after", count, exp[23:0]);
    end

    // 4. full-range wrap on the 8-bit build (count8 is 0 after the reset)
    gv8 = 8'hFF;
    repeat (254) @(posedge clk);
    #1 check("t4_fe", {16'h0000, count8}, 24'h0000FE);
    @(posedge clk); #1;
    check("t4_ff", {16'h0000, count8}, 24'h0000FF);
    @(posedge clk); #1;
    check("t4_wrap", {16'h0000, count8}, 24'h000000);

    // 5. terminal lowered below the count: runs to all-ones, then obeys 5
    gv8 = 8'd20;
    repeat (15) @(posedge clk);
    #1 check("t5_at15", {16'h0000, count8}, 24'd15);
    gv8 = 8'd5;
    for (k = 1; k <= 247; k++) begin
      @(posedge clk); #1;
      exp = (k <= 240) ? (15 + k) : ((k - 241) % 6);
      check("t5_seq", {16'h0000, count8}, exp[23:0]);
    end

    // 6. terminal raised from 5 to 8 while count=3
    gv = 24'd5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (count == 24'd3) found = 1'b1;
    end
    check("t6_reach3", count, 24'd3);
    gv = 24'd8;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp = (i < 5) ? (4 + i) : 0;
      check("t6_seq", count, exp[23:0]);
    end

    // Random phase: terminal changes, occasional short reset pulses
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) gv  = 24'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) gv8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
        check("rand_rst", count, 24'd0);
      end
    end

    @(posedge clk); #1;
    model_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_twofour_counter
